// File: rtl/pipeline_dmem_responder.sv
// Data-memory responder for the 5-stage pipeline.
// Serves the S3 data-memory port with a 256-word synchronous RAM (write-first)
// and a small MMIO page: switches, LEDs, a free-running cycle counter and a
// saturating RAM-store counter. Read data is registered and valid one cycle
// after the address is presented.
module pipeline_dmem_responder #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned RAM_DEPTH = 256,
    parameter int unsigned SW_W      = 10,
    parameter int unsigned LED_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] wdata_mem,
    input  logic              write_mem,
    output logic [DATA_W-1:0] rdata_mem,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  led_out,
    output logic [DATA_W-1:0] store_cnt_dbg
);

    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

    // MMIO page lives where the top address bit is set.
    localparam logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(1) << (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_SW   = MMIO_BASE;
    localparam logic [ADDR_W-1:0] ADDR_LED  = MMIO_BASE + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_CYC  = MMIO_BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_STC  = MMIO_BASE + ADDR_W'(3);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [RAM_DEPTH];

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [LED_W-1:0]  led_q,   led_d;
    logic [DATA_W-1:0] cyc_q,   cyc_d;
    logic [DATA_W-1:0] stc_q,   stc_d;
    logic [SW_W-1:0]   sw_meta_q;
    logic [SW_W-1:0]   sw_sync_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              is_ram;
    logic              is_led;
    logic              is_cyc;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;

    // Decode the presented address into its target and the RAM write strobe.
    always_comb begin
        is_ram  = ~addr_mem[ADDR_W-1];
        is_led  = (addr_mem == ADDR_LED);
        is_cyc  = (addr_mem == ADDR_CYC);
        ram_idx = addr_mem[RAM_AW-1:0];
        // A store sitting on the port while reset is held must not land.
        ram_we  = write_mem & is_ram & rst_n;
    end

    // ------------------------------------------------------------------
    // RAM array (not reset)
    // ------------------------------------------------------------------

    // Synchronous RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= wdata_mem;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Read mux with write-first forwarding for the writable targets.
    always_comb begin
        rdata_d = '0;
        if (is_ram) begin
            rdata_d = write_mem ? wdata_mem : mem_q[ram_idx];
        end else begin
            case (addr_mem)
                ADDR_SW:  rdata_d = DATA_W'(sw_sync_q);
                ADDR_LED: rdata_d = write_mem ? wdata_mem : DATA_W'(led_q);
                ADDR_CYC: rdata_d = write_mem ? wdata_mem : cyc_q;
                ADDR_STC: rdata_d = stc_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    // LED register loads on a store to its address.
    always_comb begin
        led_d = led_q;
        if (write_mem && is_led) begin
            led_d = wdata_mem[LED_W-1:0];
        end
    end

    // Cycle counter: a store overrides the free-running increment.
    always_comb begin
        cyc_d = cyc_q + DATA_W'(1);
        if (write_mem && is_cyc) begin
            cyc_d = wdata_mem;
        end
    end

    // Store counter: counts RAM stores only, saturating at all-ones.
    always_comb begin
        stc_d = stc_q;
        if (write_mem && is_ram && (stc_q != '1)) begin
            stc_d = stc_q + DATA_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // All control/status registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            led_q     <= '0;
            cyc_q     <= '0;
            stc_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            cyc_q     <= cyc_d;
            stc_q     <= stc_d;
            // Two-flop synchronizer for the asynchronous board switches.
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Outputs come straight from registers.
    always_comb begin
        rdata_mem     = rdata_q;
        led_out       = led_q;
        store_cnt_dbg = stc_q;
    end

endmodule
